// File: rtl/rx_fsrc_pkg.sv
// Shared types and helpers for the RX fractional sample-rate converter.
// Covers the converter state enum, the drop-mask popcount and the sample-slot bit offsets.
package rx_fsrc_pkg;

    typedef enum logic [1:0] {
        ST_BYPASS = 2'd0,
        ST_ARMED  = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam int MAX_SLOTS = 32;

    function automatic logic [5:0] popcount(input logic [MAX_SLOTS-1:0] mask);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            n = n + 6'(mask[i]);
        end
        return n;
    endfunction

    function automatic int chan_lsb(input int c, input int spc, input int w);
        return c * spc * w;
    endfunction

    function automatic int slot_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/rx_fsrc_compact.sv
// Per-channel compaction: appends the kept slots of a beat to the residual samples
// and presents a full SPC-sample beat once enough samples have been collected.
module rx_fsrc_compact
    import rx_fsrc_pkg::*;
#(
    parameter int SPC = 1,
    parameter int W   = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           advance,
    input  logic [SPC-1:0] drop,
    input  logic [SPC*W-1:0] slots,
    output logic [SPC*W-1:0] beat,
    output logic           beat_valid
);

    localparam int CW = $clog2(2 * SPC);

    // Only SPC-1 residual entries are ever occupied; the extra entry avoids a zero-size array at SPC=1.
    logic [W-1:0]  res      [SPC];
    logic [W-1:0]  res_next [SPC];
    logic [W-1:0]  merged   [2*SPC];
    logic [CW-1:0] res_cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        int pos;
        pos = int'(res_cnt);
        beat = '0;
        for (int p = 0; p < 2 * SPC; p++) begin
            merged[p] = '0;
        end
        for (int p = 0; p < SPC; p++) begin
            if (p < int'(res_cnt)) merged[p] = res[p];
        end
        for (int k = 0; k < SPC; k++) begin
            if (!drop[k]) begin
                for (int p = 0; p < 2 * SPC; p++) begin
                    if (p == pos) merged[p] = slots[slot_lsb(k, W) +: W];
                end
                pos = pos + 1;
            end
        end
        beat_valid = (pos >= SPC);
        for (int i = 0; i < SPC; i++) begin
            beat[slot_lsb(i, W) +: W] = merged[i];
            res_next[i] = beat_valid ? merged[i+SPC] : merged[i];
        end
        cnt_next = beat_valid ? CW'(pos - SPC) : CW'(pos);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_cnt <= '0;
            for (int i = 0; i < SPC; i++) res[i] <= '0;
        end else if (clear) begin
            res_cnt <= '0;
        end else if (advance) begin
            res_cnt <= cnt_next;
            for (int i = 0; i < SPC; i++) res[i] <= res_next[i];
        end
    end

endmodule

// File: rtl/rx_fsrc.sv
// RX fractional sample-rate converter: per-slot phase accumulators decide which samples
// are dropped, survivors are compacted per channel into full output beats.
//   state     | meaning
//   ST_BYPASS | enable low, beats copied straight through
//   ST_ARMED  | enabled, beats copied, waiting for start
//   ST_RUN    | accumulators advance, carry-out drops the slot
module rx_fsrc
    import rx_fsrc_pkg::*;
#(
    parameter int NUM_OF_CHANNELS     = 4,
    parameter int SAMPLES_PER_CHANNEL = 1,
    parameter int SAMPLE_DATA_WIDTH   = 16,
    parameter int ACCUM_WIDTH         = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic start,
    input  logic stop,
    input  logic accum_set,
    input  logic [SAMPLES_PER_CHANNEL*ACCUM_WIDTH-1:0] accum_set_val,
    input  logic [ACCUM_WIDTH-1:0] accum_add_val,
    input  logic in_valid,
    output logic in_ready,
    input  logic [NUM_OF_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_DATA_WIDTH-1:0] in_data,
    output logic out_valid,
    input  logic out_ready,
    output logic [NUM_OF_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_DATA_WIDTH-1:0] out_data,
    output logic running,
    output logic [31:0] drop_count
);

    localparam int NCH    = NUM_OF_CHANNELS;
    localparam int SPC    = SAMPLES_PER_CHANNEL;
    localparam int W      = SAMPLE_DATA_WIDTH;
    localparam int A      = ACCUM_WIDTH;
    localparam int BEAT_W = NCH * SPC * W;

    state_t state, state_next;
    logic accepted, run_beat, leave_run;
    logic [A-1:0] acc [SPC];
    logic [A:0]   sum [SPC];
    logic [SPC-1:0] drop;
    logic [NCH-1:0] beat_valid;
    logic [BEAT_W-1:0] beat_data;
    logic [32:0] cnt_sum;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_BYPASS;
        else       state <= state_next;
    end

    // stop takes priority over start when both pulse together
    always_comb begin
        state_next = state;
        case (state)
            ST_BYPASS: if (enable) state_next = ST_ARMED;
            ST_ARMED: begin
                if (!enable)             state_next = ST_BYPASS;
                else if (start && !stop) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!enable)   state_next = ST_BYPASS;
                else if (stop) state_next = ST_ARMED;
            end
            default: state_next = ST_BYPASS;
        endcase
    end

    assign running   = (state == ST_RUN);
    assign in_ready  = !out_valid || out_ready;
    assign accepted  = in_valid && in_ready;
    assign run_beat  = accepted && running;
    assign leave_run = running && (state_next != ST_RUN);

    always_comb begin
        for (int k = 0; k < SPC; k++) begin
            sum[k]  = {1'b0, acc[k]} + {1'b0, accum_add_val};
            drop[k] = run_beat && !accum_set && sum[k][A];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < SPC; k++) begin
            if (reset)          acc[k] <= '0;
            else if (accum_set) acc[k] <= accum_set_val[k*A +: A];
            else if (run_beat)  acc[k] <= sum[k][A-1:0];
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        rx_fsrc_compact #(.SPC(SPC), .W(W)) u_compact (
            .clk        (clk),
            .reset      (reset),
            .clear      (leave_run),
            .advance    (run_beat),
            .drop       (drop),
            .slots      (in_data[chan_lsb(c, SPC, W) +: SPC*W]),
            .beat       (beat_data[chan_lsb(c, SPC, W) +: SPC*W]),
            .beat_valid (beat_valid[c])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accepted && !running) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (run_beat && (&beat_valid)) begin
            out_valid <= 1'b1;
            out_data  <= beat_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign cnt_sum = {1'b0, drop_count} + 33'(popcount(MAX_SLOTS'(drop)));

    always_ff @(posedge clk) begin
        if (reset)         drop_count <= '0;
        else if (run_beat) drop_count <= cnt_sum[32] ? '1 : cnt_sum[31:0];
    end

endmodule
